pwm_ramp_ctrl: RTL and testbench

Autonomous duty-cycle sequencer that drives the 8-bit duty register input of the PWM peripheral. It ramps the duty value toward a target in programmable steps at a programmable interval. It supports one-shot ramps and a continuous "breathing" loop between a low bound and the target. It sits between the SPI register file and the PWM peripheral; the top level muxes its output onto the PWM duty input when ramping is enabled.

---
 rtl/pwm_ramp_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: one-shot ramps and lo/target bounce loops.
// Define PWM_RAMP_DWELL_EN to add an endpoint dwell (HOLD) in loop mode.
module pwm_ramp_ctrl #(
  parameter int DUTY_W      = 8,
  parameter int DIV_W       = 16,
  parameter int DWELL_STEPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_val,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] lo_bound,
  input  logic [DUTY_W-1:0] step,
  input  logic [DIV_W-1:0]  interval,
  input  logic              loop_mode,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              dir_up,
  output logic              done
);

`ifdef PWM_RAMP_DWELL_EN
  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;
  localparam state_t TO_UP = HOLD;
  localparam state_t TO_DN = HOLD;
  localparam int DW_W = DIV_W + $clog2(DWELL_STEPS + 1) + 1;
`else
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam state_t TO_UP = UP;
  localparam state_t TO_DN = DOWN;
`endif

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] lo_q, lo_d;
  logic [DUTY_W-1:0] stp_q, stp_d;
  logic [DIV_W-1:0]  ivl_q, ivl_d;
  logic              loop_q, loop_d;

`ifdef PWM_RAMP_DWELL_EN
  logic [DW_W-1:0] dw_q, dw_d, hold_last;
  assign hold_last = DW_W'(DWELL_STEPS)
                   * (DW_W'(ivl_q) + DW_W'(1))
                   - DW_W'(1);
`endif

  logic              tick;
  logic              loop_in;
  logic [DUTY_W-1:0] stp_in;
  logic [DUTY_W:0]   sum;
  logic [DUTY_W:0]   lim;
  logic [DUTY_W-1:0] end_v;
  logic [DUTY_W-1:0] up_v;
  logic [DUTY_W-1:0] dn_v;

  assign tick    = (cnt_q == ivl_q);
  assign stp_in  = (step == '0) ? DUTY_W'(1) : step;
  assign loop_in = loop_mode && (lo_bound < target);
  assign end_v   = loop_q ? lo_q : tgt_q;
  // Sums carry one extra bit so neither edge can wrap.
  assign sum  = {1'b0, duty_q} + {1'b0, stp_q};
  assign lim  = {1'b0, end_v} + {1'b0, stp_q};
  assign up_v = (sum > {1'b0, tgt_q}) ? tgt_q
                                      : sum[DUTY_W-1:0];
  assign dn_v = ({1'b0, duty_q} < lim) ? end_v
                                       : duty_q - stp_q;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    lo_d    = lo_q;
    stp_d   = stp_q;
    ivl_d   = ivl_q;
    loop_d  = loop_q;
`ifdef PWM_RAMP_DWELL_EN
    dw_d    = dw_q;
`endif
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      tgt_d  = target;
      lo_d   = lo_bound;
      stp_d  = stp_in;
      ivl_d  = interval;
      loop_d = loop_in;
      cnt_d  = '0;
      if (target > duty_q) begin
        state_d = UP;
        dir_d   = 1'b1;
      end else if (target < duty_q || loop_in) begin
        state_d = DOWN;
        dir_d   = 1'b0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) duty_d = load_val;
        end
        UP: begin
          if (tick) begin
            cnt_d  = '0;
            duty_d = up_v;
            if (up_v == tgt_q) begin
              if (loop_q) begin
                dir_d   = 1'b0;
                state_d = TO_DN;
`ifdef PWM_RAMP_DWELL_EN
                dw_d    = '0;
`endif
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        DOWN: begin
          if (tick) begin
            cnt_d  = '0;
            duty_d = dn_v;
            if (dn_v == end_v) begin
              if (loop_q) begin
                dir_d   = 1'b1;
                state_d = TO_UP;
`ifdef PWM_RAMP_DWELL_EN
                dw_d    = '0;
`endif
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
`ifdef PWM_RAMP_DWELL_EN
        HOLD: begin
          if (dw_q == hold_last) begin
            state_d = dir_q ? UP : DOWN;
            cnt_d   = '0;
          end else begin
            dw_d = dw_q + DW_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      lo_q    <= '0;
      stp_q   <= DUTY_W'(1);
      ivl_q   <= '0;
      loop_q  <= 1'b0;
`ifdef PWM_RAMP_DWELL_EN
      dw_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      lo_q    <= lo_d;
      stp_q   <= stp_d;
      ivl_q   <= ivl_d;
      loop_q  <= loop_d;
`ifdef PWM_RAMP_DWELL_EN
      dw_q    <= dw_d;
`endif
    end
  end

  assign duty_out = duty_q;
  assign busy     = (state_q != IDLE);
  assign dir_up   = dir_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed literals plus randomized stimulus
// compared every cycle against an event-time reference model.
module tb_pwm_ramp_ctrl;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = '0;
  logic [7:0]  target = '0;
  logic [7:0]  lo_bound = '0;
  logic [7:0]  step = '0;
  logic [15:0] interval = '0;
  logic        loop_mode = 1'b0;
  logic [7:0]  duty_out;
  logic        busy;
  logic        dir_up;
  logic        done;

  pwm_ramp_ctrl #(.DUTY_W(8), .DIV_W(16), .DWELL_STEPS(DWELL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .load(load), .load_val(load_val), .target(target),
    .lo_bound(lo_bound), .step(step), .interval(interval),
    .loop_mode(loop_mode), .duty_out(duty_out), .busy(busy),
    .dir_up(dir_up), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 up, 2 down, 3 dwell.
  // Updates happen at absolute edge numbers rather than via a counter.
  int     m_duty = 0, m_dir = 1, m_done = 0, m_ph = 0;
  int     l_tgt = 0, l_lo = 0, l_stp = 1, l_ivl = 0, goal = 0;
  bit     l_loop = 1'b0;
  longint ec = 0, nxt = 0, hend = 0;

  always @(posedge clk) begin
    ec++;
    if (rst) begin
      m_duty = 0; m_ph = 0; m_dir = 1; m_done = 0;
    end else begin
      m_done = 0;
      if (stop) begin
        m_ph = 0;
      end else if (start) begin
        l_tgt  = target;
        l_lo   = lo_bound;
        l_stp  = (step == 0) ? 1 : int'(step);
        l_ivl  = interval;
        l_loop = loop_mode && (lo_bound < target);
        nxt    = ec + l_ivl + 1;
        if (l_tgt > m_duty) begin
          m_ph = 1; m_dir = 1;
        end else if (l_tgt < m_duty || l_loop) begin
          m_ph = 2; m_dir = 0;
        end else begin
          m_ph = 0; m_done = 1;
        end
      end else if (m_ph == 0) begin
        if (load) m_duty = load_val;
      end else if (m_ph == 3) begin
        if (ec == hend) begin
          m_ph = m_dir ? 1 : 2;
          nxt  = ec + l_ivl + 1;
        end
      end else if (ec == nxt) begin
        nxt = ec + l_ivl + 1;
        if (m_ph == 1) begin
          goal   = l_tgt;
          m_duty = (m_duty + l_stp > goal) ? goal : m_duty + l_stp;
        end else begin
          goal   = l_loop ? l_lo : l_tgt;
          m_duty = (m_duty - l_stp < goal) ? goal : m_duty - l_stp;
        end
        if (m_duty == goal) begin
          if (!l_loop) begin
            m_ph = 0; m_done = 1;
          end else begin
            m_dir = (m_ph == 2);
`ifdef PWM_RAMP_DWELL_EN
            m_ph = 3;
            hend = ec + DWELL * (l_ivl + 1);
`else
            m_ph = m_dir ? 1 : 2;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", duty_out, m_duty);
      check("busy", busy, (m_ph != 0));
      check("dir", dir_up, m_dir);
      check("done", done, m_done);
      check("done_busy_excl", done & busy, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int t, input int s, input int iv);
    target = 8'(t); step = 8'(s); interval = 16'(iv);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic ld(input int v);
    load_val = 8'(v); load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    tick(1);
    chk_en = 1'b1;
    check("rst_duty", duty_out, 0);
    check("rst_busy", busy, 0);
    check("rst_dir", dir_up, 1);
    tick(1);
    rst = 1'b0;

    go(100, 10, 3);
    check("t1_busy", busy, 1);
    tick(3);
    check("t1_pre", duty_out, 0);
    tick(1);
    check("t1_first", duty_out, 10);
    tick(36);
    check("t1_end", duty_out, 100);
    check("t1_done", done, 1);
    check("t1_idle", busy, 0);
    tick(1);
    check("t1_done_pulse", done, 0);

    ld(250);
    check("sat_load", duty_out, 250);
    go(255, 10, 0);
    tick(1);
    check("sat_top", duty_out, 255);
    check("sat_top_done", done, 1);
    go(3, 10, 0);
    tick(1);
    check("sat_dn1", duty_out, 245);
    tick(25);
    check("sat_floor", duty_out, 3);
    check("sat_done", done, 1);

    ld(20);
    lo_bound = 8'd20; loop_mode = 1'b1;
    go(60, 20, 0);
`ifndef PWM_RAMP_DWELL_EN
    tick(1);
    check("loop_40", duty_out, 40);
    tick(1);
    check("loop_60", duty_out, 60);
    check("loop_dir_dn", dir_up, 0);
    tick(2);
    check("loop_20", duty_out, 20);
    check("loop_dir_up", dir_up, 1);
    tick(1);
    check("loop_40b", duty_out, 40);
`else
    tick(20);
`endif
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    loop_mode = 1'b0; lo_bound = '0;
    check("loop_stop", busy, 0);

    ld(0);
    go(100, 10, 0);
    tick(3);
    check("stop_pre", duty_out, 30);
    stop = 1'b1; start = 1'b1; target = 8'd200;
    tick(1);
    stop = 1'b0; start = 1'b0;
    check("stop_duty", duty_out, 30);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    tick(1);
    check("stop_start_dropped", busy, 0);

    ld(5);
    go(8, 0, 0);
    tick(1);
    check("step0", duty_out, 6);
    tick(2);
    check("step0_end", duty_out, 8);
    go(8, 3, 0);
    check("eq_done", done, 1);
    check("eq_busy", busy, 0);
    go(50, 1, 5);
    ld(200);
    check("load_busy", duty_out, 8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_duty", duty_out, 0);
    check("rst_mid_busy", busy, 0);

    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 11) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      load      = ($urandom_range(0, 7) == 0);
      load_val  = 8'($urandom);
      target    = 8'($urandom);
      lo_bound  = 8'($urandom);
      step      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                              : 8'($urandom_range(1, 90));
      interval  = 16'($urandom_range(0, 3));
      loop_mode = 1'($urandom);
      tick(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
